// File: rtl/synth_pkg.sv
// Shared constants and types for the FM synth control core: register map,
// field widths and the mixer state encoding.
package synth_pkg;

  localparam logic [7:0] ADDR_KEYON_WR  = 8'hF0;
  localparam logic [7:0] ADDR_KEYON_SET = 8'hF1;
  localparam logic [7:0] ADDR_KEYON_CLR = 8'hF2;
  localparam logic [7:0] ADDR_SHIFT     = 8'hF3;

  localparam logic [3:0] OFF_ALG       = 4'h0;
  localparam logic [3:0] OFF_AMP_BASE  = 4'h1;
  localparam logic [3:0] OFF_FREQ_BASE = 4'h2;

  localparam int AMP_WIDTH   = 16;
  localparam int FREQ_WIDTH  = 24;
  localparam int REG_WIDTH   = 24;
  localparam int SHIFT_WIDTH = 3;

  typedef enum logic [1:0] {
    MIX_IDLE  = 2'd0,
    MIX_ACCUM = 2'd1,
    MIX_DONE  = 2'd2
  } mix_state_t;

endpackage

// File: rtl/poly_synth_ctrl_if.sv
// Host register bus: address/data/strobes from the host, registered read-back
// from the control core.
interface poly_synth_ctrl_if;
  logic [7:0]  RegisterNumber;
  logic [23:0] RegisterValue;
  logic        RegisterWriteEnable;
  logic        RegisterReadEnable;
  logic [23:0] ReadData;
  logic        ReadValid;

  modport master (
    output RegisterNumber, RegisterValue, RegisterWriteEnable, RegisterReadEnable,
    input  ReadData, ReadValid
  );

  modport slave (
    input  RegisterNumber, RegisterValue, RegisterWriteEnable, RegisterReadEnable,
    output ReadData, ReadValid
  );
endinterface

// File: rtl/poly_synth_ctrl_mixer.sv
// Sequential saturating mixer: latches all voice samples on a strobe, sums one
// voice per cycle, then shifts and clamps the sum into the output sample.
module sample_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                                 i_Clock,
  input  logic                                 i_Reset_n,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   i_VoiceSamples,
  input  logic                                 i_SampleStrobe,
  input  logic [SHIFT_WIDTH-1:0]               i_Shift,
  output logic [SAMPLE_WIDTH-1:0]              o_Sample,
  output logic                                 o_SampleValid,
  output logic                                 o_Overrun
);

  localparam int ACC_W = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int EXT_W = ACC_W - SAMPLE_WIDTH + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{EXT_W{1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{EXT_W{1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  mix_state_t                      r_state;
  logic signed [ACC_W-1:0]         r_acc;
  logic [IDX_W-1:0]                r_idx;
  logic signed [SAMPLE_WIDTH-1:0]  r_samples [NUM_VOICES];
  logic [SAMPLE_WIDTH-1:0]         r_sample;
  logic                            r_valid;
  logic                            r_overrun;

  logic signed [ACC_W-1:0]         w_shifted;
  logic signed [ACC_W-1:0]         w_sat_wide;
  logic [SAMPLE_WIDTH-1:0]         w_sat;

  // Shift is sampled live so a host write mid-mix lands in this mix's DONE cycle.
  always_comb begin
    w_shifted = r_acc >>> i_Shift;
    if (w_shifted > SAT_MAX)
      w_sat_wide = SAT_MAX;
    else if (w_shifted < SAT_MIN)
      w_sat_wide = SAT_MIN;
    else
      w_sat_wide = w_shifted;
    w_sat = w_sat_wide[SAMPLE_WIDTH-1:0];
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state   <= MIX_IDLE;
      r_acc     <= '0;
      r_idx     <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++)
        r_samples[v] <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        MIX_IDLE: begin
          if (i_SampleStrobe) begin
            for (int v = 0; v < NUM_VOICES; v++)
              r_samples[v] <= i_VoiceSamples[v*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= MIX_ACCUM;
          end
        end
        MIX_ACCUM: begin
          r_overrun <= i_SampleStrobe;
          r_acc     <= r_acc + ACC_W'(r_samples[r_idx]);
          if (r_idx == IDX_W'(NUM_VOICES - 1))
            r_state <= MIX_DONE;
          else
            r_idx <= r_idx + 1'b1;
        end
        MIX_DONE: begin
          r_overrun <= i_SampleStrobe;
          r_sample  <= w_sat;
          r_valid   <= 1'b1;
          r_state   <= MIX_IDLE;
        end
        default: r_state <= MIX_IDLE;
      endcase
    end
  end

  assign o_Sample      = r_sample;
  assign o_SampleValid = r_valid;
  assign o_Overrun     = r_overrun;

endmodule

// File: rtl/poly_synth_ctrl.sv
// Control core for the N-voice, M-operator FM synth: per-voice register bank,
// key-on mask with edge pulses, and the sample mixer.
module poly_synth_ctrl
  import synth_pkg::*;
#(
  parameter int NUM_VOICES    = 4,
  parameter int NUM_OPERATORS = 2,
  parameter int ALG_WIDTH     = 3,
  parameter int SAMPLE_WIDTH  = 24
) (
  input  logic                                          i_Clock,
  input  logic                                          i_Reset_n,
  poly_synth_ctrl_if.slave                              bus,
  output logic [NUM_VOICES*ALG_WIDTH-1:0]               o_Algorithm,
  output logic [NUM_VOICES*NUM_OPERATORS*AMP_WIDTH-1:0] o_AmplitudeFactor,
  output logic [NUM_VOICES*NUM_OPERATORS*FREQ_WIDTH-1:0] o_Frequency,
  output logic [NUM_VOICES-1:0]                         o_KeyOn,
  output logic [NUM_VOICES-1:0]                         o_KeyOnPulse,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]            i_VoiceSamples,
  input  logic                                          i_SampleStrobe,
  output logic [SAMPLE_WIDTH-1:0]                       o_Sample,
  output logic                                          o_SampleValid,
  output logic                                          o_Overrun
);

  logic [ALG_WIDTH-1:0]   r_alg  [NUM_VOICES];
  logic [AMP_WIDTH-1:0]   r_amp  [NUM_VOICES][NUM_OPERATORS];
  logic [FREQ_WIDTH-1:0]  r_freq [NUM_VOICES][NUM_OPERATORS];
  logic [NUM_VOICES-1:0]  r_key_on;
  logic [NUM_VOICES-1:0]  r_key_pulse;
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic [REG_WIDTH-1:0]   r_read_data;
  logic                   r_read_valid;

  logic [3:0]             w_voice;
  logic [3:0]             w_reg;
  logic [2:0]             w_op;
  logic                   w_voice_ok;
  logic                   w_op_ok;
  logic                   w_is_alg;
  logic                   w_is_amp;
  logic                   w_is_freq;
  logic                   w_we;
  logic [NUM_VOICES-1:0]  w_key_next;
  logic [REG_WIDTH-1:0]   w_rd_data;

  // Amp (1+2k) and freq (2+2k) offsets share the operator index (reg-1)>>1.
  always_comb begin
    w_voice    = bus.RegisterNumber[7:4];
    w_reg      = bus.RegisterNumber[3:0];
    w_op       = 3'((w_reg - OFF_AMP_BASE) >> 1);
    w_voice_ok = int'(w_voice) < NUM_VOICES;
    w_op_ok    = (w_reg != OFF_ALG) && (int'(w_op) < NUM_OPERATORS);
    w_is_alg   = w_voice_ok && (w_reg == OFF_ALG);
    w_is_amp   = w_voice_ok && w_op_ok && w_reg[0];
    w_is_freq  = w_voice_ok && w_op_ok && !w_reg[0];
    w_we       = bus.RegisterWriteEnable;
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)
          r_alg[gi] <= '0;
        else if (w_we && w_is_alg && w_voice == 4'(gi))
          r_alg[gi] <= bus.RegisterValue[ALG_WIDTH-1:0];
      end
      assign o_Algorithm[gi*ALG_WIDTH +: ALG_WIDTH] = r_alg[gi];

      for (gj = 0; gj < NUM_OPERATORS; gj++) begin : g_op
        always_ff @(posedge i_Clock or negedge i_Reset_n) begin
          if (!i_Reset_n) begin
            r_amp[gi][gj]  <= '0;
            r_freq[gi][gj] <= '0;
          end else if (w_we && w_voice == 4'(gi) && w_op == 3'(gj)) begin
            if (w_is_amp)
              r_amp[gi][gj] <= bus.RegisterValue[AMP_WIDTH-1:0];
            if (w_is_freq)
              r_freq[gi][gj] <= bus.RegisterValue[FREQ_WIDTH-1:0];
          end
        end
        assign o_AmplitudeFactor[(gi*NUM_OPERATORS+gj)*AMP_WIDTH +: AMP_WIDTH]  = r_amp[gi][gj];
        assign o_Frequency[(gi*NUM_OPERATORS+gj)*FREQ_WIDTH +: FREQ_WIDTH]      = r_freq[gi][gj];
      end
    end
  endgenerate

  always_comb begin
    w_key_next = r_key_on;
    if (w_we) begin
      case (bus.RegisterNumber)
        ADDR_KEYON_WR:  w_key_next = bus.RegisterValue[NUM_VOICES-1:0];
        ADDR_KEYON_SET: w_key_next = r_key_on | bus.RegisterValue[NUM_VOICES-1:0];
        ADDR_KEYON_CLR: w_key_next = r_key_on & ~bus.RegisterValue[NUM_VOICES-1:0];
        default:        w_key_next = r_key_on;
      endcase
    end
  end

  // Reads see pre-write state, so a same-cycle write to the read address is invisible.
  always_comb begin
    w_rd_data = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (w_voice == 4'(v)) begin
        if (w_is_alg)
          w_rd_data = REG_WIDTH'(r_alg[v]);
        for (int k = 0; k < NUM_OPERATORS; k++) begin
          if (w_op == 3'(k) && w_is_amp)
            w_rd_data = REG_WIDTH'(r_amp[v][k]);
          if (w_op == 3'(k) && w_is_freq)
            w_rd_data = REG_WIDTH'(r_freq[v][k]);
        end
      end
    end
    case (bus.RegisterNumber)
      ADDR_KEYON_WR, ADDR_KEYON_SET, ADDR_KEYON_CLR: w_rd_data = REG_WIDTH'(r_key_on);
      ADDR_SHIFT:                                    w_rd_data = REG_WIDTH'(r_shift);
      default:                                       ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_key_on     <= '0;
      r_key_pulse  <= '0;
      r_shift      <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_key_on     <= w_key_next;
      r_key_pulse  <= w_key_next & ~r_key_on;
      r_read_valid <= bus.RegisterReadEnable;
      if (bus.RegisterReadEnable)
        r_read_data <= w_rd_data;
      if (w_we && bus.RegisterNumber == ADDR_SHIFT)
        r_shift <= bus.RegisterValue[SHIFT_WIDTH-1:0];
    end
  end

  assign o_KeyOn      = r_key_on;
  assign o_KeyOnPulse = r_key_pulse;
  assign bus.ReadData  = r_read_data;
  assign bus.ReadValid = r_read_valid;

  sample_mixer #(
    .NUM_VOICES   (NUM_VOICES),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_mixer (
    .i_Clock        (i_Clock),
    .i_Reset_n      (i_Reset_n),
    .i_VoiceSamples (i_VoiceSamples),
    .i_SampleStrobe (i_SampleStrobe),
    .i_Shift        (r_shift),
    .o_Sample       (o_Sample),
    .o_SampleValid  (o_SampleValid),
    .o_Overrun      (o_Overrun)
  );

endmodule

// File: tb/tb_poly_synth_ctrl.sv
// Directed bench for poly_synth_ctrl: register bank, key-on mask/pulses and
// mixer latency, saturation, overrun and mid-mix reset.
module tb_poly_synth_ctrl;

  localparam int V  = 4;
  localparam int M  = 2;
  localparam int AW = 3;
  localparam int SW = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [V*AW-1:0]   alg;
  logic [V*M*16-1:0] amp;
  logic [V*M*24-1:0] freq;
  logic [V-1:0]      key_on;
  logic [V-1:0]      key_pulse;
  logic [V*SW-1:0]   samples;
  logic              strobe;
  logic [SW-1:0]     sample;
  logic              sample_valid;
  logic              overrun;

  int n_total = 0;
  int n_bad   = 0;

  poly_synth_ctrl_if bus ();

  poly_synth_ctrl #(
    .NUM_VOICES(V), .NUM_OPERATORS(M), .ALG_WIDTH(AW), .SAMPLE_WIDTH(SW)
  ) dut (
    .i_Clock           (clk),
    .i_Reset_n         (rst_n),
    .bus               (bus),
    .o_Algorithm       (alg),
    .o_AmplitudeFactor (amp),
    .o_Frequency       (freq),
    .o_KeyOn           (key_on),
    .o_KeyOnPulse      (key_pulse),
    .i_VoiceSamples    (samples),
    .i_SampleStrobe    (strobe),
    .o_Sample          (sample),
    .o_SampleValid     (sample_valid),
    .o_Overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else
      $display("ok   %s: 0x%0h", tag, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [23:0] d);
    bus.RegisterNumber      = a;
    bus.RegisterValue       = d;
    bus.RegisterWriteEnable = 1'b1;
    tick();
    bus.RegisterWriteEnable = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [23:0] d, output logic vld);
    bus.RegisterNumber     = a;
    bus.RegisterReadEnable = 1'b1;
    tick();
    bus.RegisterReadEnable = 1'b0;
    d   = bus.ReadData;
    vld = bus.ReadValid;
  endtask

  task automatic set_samples(input int s0, input int s1, input int s2, input int s3);
    samples = {24'(s3), 24'(s2), 24'(s1), 24'(s0)};
  endtask

  // Pulse strobe for one edge, then count edges until valid (bounded).
  task automatic mix(input string tag, input logic [23:0] exp_sample);
    int n;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    n = 0;
    while (!sample_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(V + 1));
    chk({tag, "_sample"}, 64'(sample), 64'(exp_sample));
  endtask

  logic [23:0] rd;
  logic        rv;
  int          nvalid;
  logic [23:0] first_sample;

  initial begin
    rst_n = 1'b0;
    bus.RegisterNumber      = '0;
    bus.RegisterValue       = '0;
    bus.RegisterWriteEnable = 1'b0;
    bus.RegisterReadEnable  = 1'b0;
    samples = '0;
    strobe  = 1'b0;
    repeat (2) tick();
    chk("rst_keyon", 64'(key_on), 64'h0);
    chk("rst_sample", 64'(sample), 64'h0);
    chk("rst_valid", 64'({sample_valid, overrun, bus.ReadValid}), 64'h0);
    chk("rst_amp", 64'(amp), 64'h0);
    rst_n = 1'b1;
    tick();

    // Register bank write/read
    reg_write(8'h13, 24'h00ABCD);
    chk("amp_v1op1", 64'(amp[(1*M+1)*16 +: 16]), 64'hABCD);
    reg_read(8'h13, rd, rv);
    chk("rd13_data", 64'(rd), 64'h00ABCD);
    chk("rd13_valid", 64'(rv), 64'h1);
    tick();
    chk("rd_valid_drop", 64'(bus.ReadValid), 64'h0);
    reg_write(8'h50, 24'h000007);
    reg_write(8'h15, 24'h001234);
    reg_read(8'h50, rd, rv);
    chk("rd50_zero", 64'(rd), 64'h0);
    reg_read(8'h15, rd, rv);
    chk("rd15_zero", 64'(rd), 64'h0);
    chk("amp_untouched", 64'(amp), 64'(64'hABCD) << ((1*M+1)*16));
    reg_write(8'h02, 24'h123456);
    chk("freq_v0op0", 64'(freq[23:0]), 64'h123456);
    reg_write(8'h20, 24'hFFFFFF);
    chk("alg_v2", 64'(alg[2*AW +: AW]), 64'h7);
    reg_read(8'h20, rd, rv);
    chk("rd20_alg", 64'(rd), 64'h7);

    // Same-cycle read and write returns the old value
    bus.RegisterNumber      = 8'h13;
    bus.RegisterValue       = 24'h001111;
    bus.RegisterWriteEnable = 1'b1;
    bus.RegisterReadEnable  = 1'b1;
    tick();
    bus.RegisterWriteEnable = 1'b0;
    bus.RegisterReadEnable  = 1'b0;
    chk("rw_same_old", 64'(bus.ReadData), 64'h00ABCD);
    reg_read(8'h13, rd, rv);
    chk("rw_same_new", 64'(rd), 64'h001111);

    // Key-on mask and pulses
    reg_write(8'hF0, 24'h5);
    chk("key_wr", 64'(key_on), 64'h5);
    chk("pulse_wr", 64'(key_pulse), 64'h5);
    tick();
    chk("pulse_once", 64'(key_pulse), 64'h0);
    reg_write(8'hF1, 24'h2);
    chk("key_set", 64'(key_on), 64'h7);
    chk("pulse_set", 64'(key_pulse), 64'h2);
    reg_write(8'hF2, 24'h4);
    chk("key_clr", 64'(key_on), 64'h3);
    chk("pulse_clr", 64'(key_pulse), 64'h0);
    reg_read(8'hF1, rd, rv);
    chk("rd_keyon", 64'(rd), 64'h3);
    reg_write(8'hF2, 24'h1);
    reg_write(8'hF1, 24'h1);
    chk("key_rekey", 64'(key_on), 64'h3);
    chk("pulse_rekey", 64'(key_pulse), 64'h1);

    // Mixer
    reg_write(8'hF3, 24'h0);
    set_samples(1000, -200, 300, -100);
    mix("mix_basic", 24'd1000);
    tick();
    chk("valid_pulse", 64'(sample_valid), 64'h0);
    chk("sample_held", 64'(sample), 64'd1000);
    set_samples(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF);
    mix("sat_pos", 24'h7FFFFF);
    set_samples(-8388608, -8388608, -8388608, -8388608);
    mix("sat_neg", 24'h800000);
    reg_write(8'hF3, 24'h2);
    set_samples(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF);
    mix("shift2", 24'h7FFFFF);
    set_samples(-4, 6, -8, 2);
    mix("shift2_neg", 24'hFFFFFF);

    // Shift written mid-mix applies to the current result
    reg_write(8'hF3, 24'h0);
    set_samples(400, 400, 400, 400);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    reg_write(8'hF3, 24'h2);
    nvalid = 1;
    while (!sample_valid && nvalid < 20) begin
      tick();
      nvalid++;
    end
    chk("midshift_latency", 64'(nvalid), 64'(V + 1));
    chk("midshift_sample", 64'(sample), 64'd400);
    reg_write(8'hF3, 24'h0);

    // Overrun: second strobe two cycles after the first
    set_samples(10, 20, 30, 40);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    chk("no_overrun", 64'(overrun), 64'h0);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    chk("overrun", 64'(overrun), 64'h1);
    nvalid = 0;
    first_sample = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sample_valid) begin
        nvalid++;
        first_sample = sample;
      end
    end
    chk("overrun_nvalid", 64'(nvalid), 64'h1);
    chk("overrun_sample", 64'(first_sample), 64'd100);

    // Async reset mid-accumulate
    set_samples(5, 5, 5, 5);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_keyon", 64'(key_on), 64'h0);
    chk("arst_sample", 64'(sample), 64'h0);
    chk("arst_amp", 64'(amp), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sample_valid) nvalid++;
    end
    chk("arst_no_valid", 64'(nvalid), 64'h0);
    set_samples(1, 2, 3, 4);
    mix("post_rst", 24'd10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
